// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-busy scoreboard: register-file geometry
// and the hard-wired zero register index.
package reg_scoreboard_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_scoreboard_dec5to32.sv
// Index-to-one-hot decoder: a 5-bit register index plus enable becomes a
// 32-bit strobe with at most one bit set.
module dec5to32
  import reg_scoreboard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic                 i_en,
  output logic [REG_NUM-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: per-register in-flight write counters fed by
// one-hot issue/writeback strobes, plus combinational source-busy queries.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [REG_NUM-1:0]   busy_vec,
  output logic                 underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [REG_NUM-1:0][CNT_W-1:0] w_cnt;
  logic [REG_NUM-1:0]            w_set;
  logic [REG_NUM-1:0]            w_clr;
  logic                          w_inc;
  logic                          w_dec;
  logic                          w_underflow;
  logic                          w_unused;
  logic                          r_underflow;

  // Readiness looks only at the current count, so a same-cycle writeback
  // never frees a slot for the issuing instruction.
  assign issue_ready = (issue_rd == ZERO_REG) || (w_cnt[issue_rd] != CNT_MAX);
  assign w_inc       = issue_valid && issue_ready && (issue_rd != ZERO_REG);
  assign w_dec       = wb_valid && (wb_rd != ZERO_REG) && (w_cnt[wb_rd] != '0);
  assign w_underflow = wb_valid && (wb_rd != ZERO_REG) && (w_cnt[wb_rd] == '0);

  dec5to32 u_dec_set (
    .i_idx    (issue_rd),
    .i_en     (w_inc),
    .o_onehot (w_set)
  );

  dec5to32 u_dec_clr (
    .i_idx    (wb_rd),
    .i_en     (w_dec),
    .o_onehot (w_clr)
  );

  // Strobe bit 0 can never fire because both enables exclude register 0.
  assign w_unused = w_set[0] ^ w_clr[0];

  for (genvar i = 0; i < REG_NUM; i++) begin : g_cnt
    if (i == int'(ZERO_REG)) begin : g_zero
      assign w_cnt[i] = '0;
    end else begin : g_reg
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_cnt <= '0;
        end else if (w_set[i] && !w_clr[i]) begin
          r_cnt <= r_cnt + CNT_ONE;
        end else if (w_clr[i] && !w_set[i]) begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end
      assign w_cnt[i] = r_cnt;
    end
    assign busy_vec[i] = (w_cnt[i] != '0);
  end

  // Sticky error; a flush does not hide an underflow seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (w_underflow) begin
      r_underflow <= 1'b1;
    end
  end
  assign underflow_err = r_underflow;

  // A retiring last write clears the query in the same cycle.
  assign rs1_busy = (rs1 != ZERO_REG) && (w_cnt[rs1] != '0) &&
                    !(w_dec && (wb_rd == rs1) && (w_cnt[rs1] == CNT_ONE));
  assign rs2_busy = (rs2 != ZERO_REG) && (w_cnt[rs2] != '0) &&
                    !(w_dec && (wb_rd == rs2) && (w_cnt[rs2] == CNT_ONE));

endmodule
